// File: rtl/apb_master_ctrl_if.sv
// APB4 bus bundle between one requester and one completer.
interface apb_master_ctrl_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  logic                    PSEL;
  logic                    PENABLE;
  logic                    PWRITE;
  logic [ADDR_WIDTH-1:0]   PADDR;
  logic [DATA_WIDTH-1:0]   PWDATA;
  logic [DATA_WIDTH/8-1:0] PSTRB;
  logic                    PREADY;
  logic                    PSLVERR;
  logic [DATA_WIDTH-1:0]   PRDATA;

  modport master (
    output PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    input  PREADY, PSLVERR, PRDATA
  );

  modport slave (
    input  PSEL, PENABLE, PWRITE, PADDR, PWDATA, PSTRB,
    output PREADY, PSLVERR, PRDATA
  );
endinterface

// File: rtl/apb_master_ctrl.sv
// APB4 requester: one command at a time from a valid/ready port, response held until consumed,
// optional wait-state timeout so a hung completer cannot stall the requester forever.
module apb_master_ctrl #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                    PCLK,
  input  logic                    PRESETn,
  // Handshakes: a command moves when cmd_valid && cmd_ready at PCLK rise, a response is consumed
  // when rsp_valid && rsp_ready at PCLK rise; rsp_* stay stable while rsp_valid && !rsp_ready.
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_write,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_wdata,
  input  logic [DATA_WIDTH/8-1:0] cmd_strb,
  output logic                    rsp_valid,
  input  logic                    rsp_ready,
  output logic [DATA_WIDTH-1:0]   rsp_rdata,
  output logic                    rsp_err,
  output logic                    rsp_timeout,
  output logic [1:0]              dbg_state,
  apb_master_ctrl_if.master       apb
);
  localparam int CNT_WIDTH = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [CNT_WIDTH-1:0] CNT_MAX   = '1;
  localparam logic [CNT_WIDTH-1:0] CNT_LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } state_t;

  state_t               state;
  logic [CNT_WIDTH-1:0] wait_cnt;
  logic [CNT_WIDTH-1:0] wait_next;
  logic                 timeout_hit;

  // Saturating so a disabled timeout never lets the counter wrap.
  assign wait_next   = (wait_cnt == CNT_MAX) ? wait_cnt : wait_cnt + 1'b1;
  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (wait_next == CNT_LIMIT);
  assign cmd_ready   = (state == IDLE) && !rsp_valid;
  assign dbg_state   = state;

  always_ff @(posedge PCLK or negedge PRESETn) begin
    if (!PRESETn) begin
      state       <= IDLE;
      wait_cnt    <= '0;
      apb.PSEL    <= 1'b0;
      apb.PENABLE <= 1'b0;
      apb.PWRITE  <= 1'b0;
      apb.PADDR   <= '0;
      apb.PWDATA  <= '0;
      apb.PSTRB   <= '0;
      rsp_valid   <= 1'b0;
      rsp_rdata   <= '0;
      rsp_err     <= 1'b0;
      rsp_timeout <= 1'b0;
    end else begin
      if (rsp_valid && rsp_ready) begin
        rsp_valid   <= 1'b0;
        rsp_rdata   <= '0;
        rsp_err     <= 1'b0;
        rsp_timeout <= 1'b0;
      end
      case (state)
        IDLE: begin
          if (cmd_valid && cmd_ready) begin
            state       <= SETUP;
            wait_cnt    <= '0;
            apb.PSEL    <= 1'b1;
            apb.PENABLE <= 1'b0;
            apb.PADDR   <= cmd_addr;
            apb.PWRITE  <= cmd_write;
            // Reads keep the previous write data on PWDATA to avoid needless toggling.
            apb.PSTRB   <= cmd_write ? cmd_strb : '0;
            if (cmd_write) apb.PWDATA <= cmd_wdata;
          end
        end
        SETUP: begin
          state       <= ACCESS;
          apb.PENABLE <= 1'b1;
        end
        ACCESS: begin
          if (apb.PREADY) begin
            state       <= IDLE;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= apb.PWRITE ? '0 : apb.PRDATA;
            rsp_err     <= apb.PSLVERR;
            rsp_timeout <= 1'b0;
          end else if (timeout_hit) begin
            state       <= IDLE;
            wait_cnt    <= wait_next;
            apb.PSEL    <= 1'b0;
            apb.PENABLE <= 1'b0;
            rsp_valid   <= 1'b1;
            rsp_rdata   <= '0;
            rsp_err     <= 1'b1;
            rsp_timeout <= 1'b1;
          end else begin
            wait_cnt <= wait_next;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_apb_master_ctrl.sv
// Bench for apb_master_ctrl: directed vector table, reset-in-flight sequence, then random traffic
// against a memory-backed completer and a transaction-level reference model.
module tb_apb_master_ctrl;
  localparam int TMO = 16;

  logic        PCLK = 1'b0;
  logic        PRESETn = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic        cmd_write = 1'b0;
  logic [31:0] cmd_addr = '0;
  logic [31:0] cmd_wdata = '0;
  logic [3:0]  cmd_strb = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        rsp_timeout;
  logic [1:0]  dbg_state;

  apb_master_ctrl_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  apb_master_ctrl #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TMO)) dut (
    .PCLK(PCLK), .PRESETn(PRESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_strb(cmd_strb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .rsp_timeout(rsp_timeout), .dbg_state(dbg_state),
    .apb(bus.master)
  );

  // Clock / watchdog
  always #5 PCLK = ~PCLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Completer: word memory, cfg_waits wait states, junk on PRDATA/PSLVERR outside completion
  int          cfg_waits = 0;
  bit          cfg_serr = 1'b0;
  int          acc_cnt = 0;
  logic [31:0] junk = 32'h0;
  logic [31:0] mem [16] = '{default: 32'h0};

  assign bus.PREADY  = bus.PSEL && bus.PENABLE && (acc_cnt == cfg_waits);
  assign bus.PRDATA  = bus.PREADY ? mem[bus.PADDR[5:2]] : junk;
  assign bus.PSLVERR = bus.PREADY ? cfg_serr : 1'b1;

  always @(posedge PCLK) begin
    junk <= $urandom;
    if (bus.PSEL && bus.PENABLE && !bus.PREADY) acc_cnt <= acc_cnt + 1;
    else acc_cnt <= 0;
    if (bus.PREADY && bus.PWRITE && !cfg_serr)
      for (int b = 0; b < 4; b++)
        if (bus.PSTRB[b]) mem[bus.PADDR[5:2]][8*b +: 8] <= bus.PWDATA[8*b +: 8];
  end

  // Scoreboard
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] exp_pwdata = '0;
  logic [31:0] ref_mem [16] = '{default: 32'h0};

  function automatic void check(string name, logic [31:0] got, logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endfunction

  // Reference model: outcome of one transfer from the protocol rules, updating the modelled memory.
  function automatic void ref_apply(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                    input logic [3:0] strb, input int waits, input bit serr,
                                    output logic [31:0] rdata, output bit err, output bit to,
                                    output int lat);
    bit timed;
    timed = (TMO != 0) && (waits >= TMO);
    lat   = timed ? 2 + TMO : 3 + waits;
    err   = timed || serr;
    to    = timed;
    rdata = (wr || timed) ? 32'h0 : ref_mem[addr[5:2]];
    if (wr && !serr && !timed)
      for (int b = 0; b < 4; b++)
        if (strb[b]) ref_mem[addr[5:2]][8*b +: 8] = wdata[8*b +: 8];
  endfunction

  // Driver: issue one command, follow the bus, check the response, hold it, then consume it.
  task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [3:0] strb, input int waits, input bit serr, input int hold,
                         input logic [31:0] exp_rdata, input bit exp_err, input bit exp_to,
                         input int exp_lat);
    int          n;
    int          en_cycles;
    bit          bad;
    logic [31:0] r_rdata;
    logic        r_err;
    logic        r_to;
    logic [3:0]  exp_strb;
    exp_strb  = wr ? strb : 4'h0;
    cfg_waits = waits;
    cfg_serr  = serr;
    exp_q.push_back(exp_rdata);
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = wr; cmd_addr = addr; cmd_wdata = wdata; cmd_strb = strb;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge PCLK);
      n++;
    end
    check("cmd_ready", 32'(cmd_ready), 32'd1);
    if (!cmd_ready) begin
      cmd_valid = 1'b0;
      void'(exp_q.pop_back());
      return;
    end
    @(posedge PCLK);
    if (wr) exp_pwdata = wdata;
    @(negedge PCLK);
    cmd_valid = 1'b0; cmd_write = ~wr; cmd_addr = $urandom; cmd_wdata = $urandom;
    cmd_strb = 4'($urandom);
    n = 1;
    check("setup_phase", 32'({bus.PSEL, bus.PENABLE}), 32'h2);
    bad = 1'b0;
    en_cycles = 0;
    while (!rsp_valid && n < 100) begin
      if (bus.PENABLE) en_cycles++;
      if (!bus.PSEL || bus.PADDR !== addr || bus.PWRITE !== wr || bus.PSTRB !== exp_strb ||
          bus.PWDATA !== exp_pwdata) bad = 1'b1;
      @(negedge PCLK);
      n++;
    end
    check("rsp_seen", 32'(rsp_valid), 32'd1);
    check("latency", 32'(n), 32'(exp_lat));
    check("penable_cycles", 32'(en_cycles), 32'(exp_lat - 2));
    check("bus_stable", 32'(bad), 32'd0);
    check("bus_idle", 32'({bus.PSEL, bus.PENABLE}), 32'h0);
    check("paddr_retained", bus.PADDR, addr);
    check("rsp_rdata", rsp_rdata, exp_q.pop_front());
    check("rsp_err", 32'(rsp_err), 32'(exp_err));
    check("rsp_timeout", 32'(rsp_timeout), 32'(exp_to));
    r_rdata = rsp_rdata; r_err = rsp_err; r_to = rsp_timeout;
    bad = 1'b0;
    if (hold > 0) cmd_valid = 1'b1;
    for (int i = 0; i < hold; i++) begin
      @(negedge PCLK);
      if (!rsp_valid || rsp_rdata !== r_rdata || rsp_err !== r_err || rsp_timeout !== r_to ||
          cmd_ready || bus.PSEL) bad = 1'b1;
    end
    if (hold > 0) check("rsp_hold", 32'(bad), 32'd0);
    rsp_ready = 1'b1;
    @(negedge PCLK);
    rsp_ready = 1'b0;
    cmd_valid = 1'b0;
    check("rsp_cleared", 32'({rsp_valid, cmd_ready}), 32'h1);
  endtask

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  strb;
    int          waits;
    bit          serr;
    int          hold;
    logic [31:0] exp_rdata;
    bit          exp_err;
    bit          exp_to;
    int          exp_lat;
  } vec_t;

  vec_t vecs [11];

  initial begin
    logic [31:0] m_rdata;
    bit          m_err;
    bit          m_to;
    int          m_lat;
    int          r;
    int          w;

    vecs[0]  = '{1'b1, 32'h10, 32'hA5A5_0001, 4'hF, 0,    1'b0, 0, 32'h0,         1'b0, 1'b0, 3};
    vecs[1]  = '{1'b0, 32'h10, 32'h0,         4'hF, 3,    1'b0, 0, 32'hA5A5_0001, 1'b0, 1'b0, 6};
    vecs[2]  = '{1'b1, 32'h14, 32'h1122_3344, 4'h5, 1,    1'b0, 0, 32'h0,         1'b0, 1'b0, 4};
    vecs[3]  = '{1'b0, 32'h14, 32'h0,         4'hF, 0,    1'b1, 0, 32'h0022_0044, 1'b1, 1'b0, 3};
    vecs[4]  = '{1'b0, 32'h18, 32'h0,         4'h0, 1000, 1'b0, 0, 32'h0,         1'b1, 1'b1, 18};
    vecs[5]  = '{1'b1, 32'h18, 32'hDEAD_BEEF, 4'hF, 2,    1'b1, 5, 32'h0,         1'b1, 1'b0, 5};
    vecs[6]  = '{1'b0, 32'h18, 32'h0,         4'hF, 15,   1'b0, 0, 32'h0,         1'b0, 1'b0, 18};
    vecs[7]  = '{1'b1, 32'h1C, 32'hCAFE_F00D, 4'hA, 16,   1'b0, 0, 32'h0,         1'b1, 1'b1, 18};
    vecs[8]  = '{1'b0, 32'h1C, 32'h0,         4'h0, 0,    1'b0, 2, 32'h0,         1'b0, 1'b0, 3};
    vecs[9]  = '{1'b1, 32'h1C, 32'h0BAD_F00D, 4'h3, 0,    1'b0, 0, 32'h0,         1'b0, 1'b0, 3};
    vecs[10] = '{1'b0, 32'h1C, 32'h0,         4'hF, 0,    1'b0, 1, 32'h0000_F00D, 1'b0, 1'b0, 3};

    // Reset state
    repeat (3) @(negedge PCLK);
    check("reset_bus", 32'({bus.PSEL, bus.PENABLE, bus.PWRITE}), 32'h0);
    check("reset_paddr", bus.PADDR, 32'h0);
    check("reset_pwdata", bus.PWDATA, 32'h0);
    check("reset_pstrb", 32'(bus.PSTRB), 32'h0);
    check("reset_rsp", 32'({rsp_valid, rsp_err, rsp_timeout}), 32'h0);
    check("reset_rdata", rsp_rdata, 32'h0);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("ready_after_reset", 32'(cmd_ready), 32'd1);

    // Directed vectors
    foreach (vecs[i]) begin
      ref_apply(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].waits,
                vecs[i].serr, m_rdata, m_err, m_to, m_lat);
      run_txn(vecs[i].wr, vecs[i].addr, vecs[i].wdata, vecs[i].strb, vecs[i].waits,
              vecs[i].serr, vecs[i].hold, vecs[i].exp_rdata, vecs[i].exp_err, vecs[i].exp_to,
              vecs[i].exp_lat);
    end

    // Reset while a write sits in ACCESS: dropped, no response, no memory update
    cfg_waits = 1000;
    cfg_serr  = 1'b0;
    @(negedge PCLK);
    cmd_valid = 1'b1; cmd_write = 1'b1; cmd_addr = 32'h20; cmd_wdata = 32'h5555_AAAA;
    cmd_strb = 4'hF;
    @(posedge PCLK);
    @(negedge PCLK);
    cmd_valid = 1'b0;
    @(negedge PCLK);
    check("inflight_access", 32'({bus.PSEL, bus.PENABLE}), 32'h3);
    #2 PRESETn = 1'b0;
    #1;
    check("async_reset_bus", 32'({bus.PSEL, bus.PENABLE, rsp_valid}), 32'h0);
    check("async_reset_pwdata", bus.PWDATA, 32'h0);
    exp_pwdata = 32'h0;
    @(negedge PCLK);
    PRESETn = 1'b1;
    @(negedge PCLK);
    check("no_rsp_after_reset", 32'(rsp_valid), 32'd0);
    ref_apply(1'b0, 32'h20, 32'h0, 4'hF, 1, 1'b0, m_rdata, m_err, m_to, m_lat);
    run_txn(1'b0, 32'h20, 32'h0, 4'hF, 1, 1'b0, 0, m_rdata, m_err, m_to, m_lat);

    // Random traffic against the reference model
    for (int t = 0; t < 40; t++) begin
      logic [31:0] a;
      logic [31:0] d;
      logic [3:0]  s;
      bit          wr;
      bit          se;
      a  = 32'($urandom_range(0, 15)) << 2;
      d  = $urandom;
      s  = 4'($urandom_range(0, 15));
      wr = 1'($urandom_range(0, 1));
      se = ($urandom_range(0, 4) == 0);
      r  = $urandom_range(0, 9);
      w  = (r == 0) ? TMO + $urandom_range(0, 4) : $urandom_range(0, 4);
      ref_apply(wr, a, d, s, w, se, m_rdata, m_err, m_to, m_lat);
      run_txn(wr, a, d, s, w, se, $urandom_range(0, 3), m_rdata, m_err, m_to, m_lat);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
